// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO holding {addr, inst} entries
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   flush      empty the buffer (wins over push/pop)
//   push, din  write one entry at the tail
//   pop        drop the head entry
//   head       current head entry (meaningless while empty)
//   empty      buffer holds no entries
//   count      number of stored entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  entry_t                       din,
    input  logic                         pop,
    output entry_t                       head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            // Push and pop together (even when full) leave the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, outstanding tracking, redirect, buffer
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   Stall                    hold the presented instruction
//   Flush, br_target         branch/jump redirect
//   csr_Flush, csr_target    trap/mret redirect (priority over Flush)
//   imem_req, imem_addr      fetch request, accepted in the cycle it is raised
//   imem_rvalid, imem_rdata  in-order fetch responses
//   Addr, Inst, InstValid    presented instruction
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] br_target,
    input  logic        csr_Flush,
    input  logic [31:0] csr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Addr,
    output logic [31:0] Inst,
    output logic        InstValid
);

    localparam int           CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]    pc;
    // Address the next kept response belongs to. Requests are issued
    // sequentially from the last redirect target, so this simply walks
    // forward by one word per accepted response.
    logic [31:0]    resp_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop_cnt;

    logic           redirect;
    logic [31:0]    target;
    logic           discard;
    logic           push;
    logic           pop;
    logic           empty;
    logic [CW-1:0]  buf_count;
    logic [CW:0]    inflight;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;

    assign redirect = csr_Flush | Flush;
    assign target   = csr_Flush ? csr_target : br_target;

    assign inflight  = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req  = rst && !redirect && (inflight < DEPTH_W);
    assign imem_addr = pc;

    // Responses belonging to a flushed stream, including one arriving in
    // the redirect cycle itself, never reach the buffer.
    assign discard = imem_rvalid && (redirect || (drop_cnt != '0));
    assign push    = imem_rvalid && !discard;
    assign pop     = !Stall && !empty && !redirect;

    assign push_entry.addr = resp_pc;
    assign push_entry.inst = imem_rdata;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .empty (empty),
        .count (buf_count)
    );

    assign InstValid = !empty;
    assign Addr      = empty ? 32'h0 : head.addr;
    assign Inst      = empty ? NOP   : head.inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // No request issues in a redirect cycle; every request still in
            // flight after this edge is stale.
            pc          <= target;
            resp_pc     <= target;
            outstanding <= outstanding - CW'(imem_rvalid);
            drop_cnt    <= outstanding - CW'(imem_rvalid);
        end else begin
            if (imem_req) pc <= pc + 32'd4;
            if (push)     resp_pc <= resp_pc + 32'd4;
            if (imem_req && !imem_rvalid)
                outstanding <= outstanding + CW'(1);
            else if (!imem_req && imem_rvalid)
                outstanding <= outstanding - CW'(1);
            if (imem_rvalid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

endmodule
